wb_addr_mux: RTL and testbench
==============================

Name: wb_addr_mux

Overview:
- Wishbone B3/B4 1-master-to-N-slave address decoder and multiplexer.
- Sits between a single bus master (CPU or test master) and N memory-mapped slaves.
- Decodes each master address against per-slave match/mask pairs, routes cycle/strobe to exactly one slave, and returns that slave's response.
- Unmapped addresses are terminated with a bus error.

Parameters:
- num_slaves, 2, number of slave ports (N ≥ 1).
- aw, 32, address width.
- dw, 32, data width; byte-select width is dw/8.
- MATCH_ADDR, all zeros (N*aw bits), slave i base address in bits [i*aw +: aw].
- MATCH_MASK, all zeros (N*aw bits), slave i compare mask in bits [i*aw +: aw].

Ports:
- wb_clk_i  in  1  clock; all state updates on the rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset.
- wbm_adr_i  in  aw  master address.
- wbm_dat_i  in  dw  master write data.
- wbm_sel_i  in  dw/8  byte selects.
- wbm_we_i  in  1  write enable.
- wbm_cyc_i  in  1  cycle.
- wbm_stb_i  in  1  strobe.
- wbm_cti_i  in  3  cycle type.
- wbm_bte_i  in  2  burst type.
- wbm_rdt_o  out  dw  read data to master.
- wbm_ack_o  out  1  ack to master.
- wbm_err_o  out  1  error to master.
- wbm_rty_o  out  1  retry to master.
- wbs_adr_o  out  N*aw  per-slave address.
- wbs_dat_o  out  N*dw  per-slave write data.
- wbs_sel_o  out  N*dw/8  per-slave byte selects.
- wbs_we_o  out  N  per-slave write enable.
- wbs_cyc_o  out  N  per-slave cycle.
- wbs_stb_o  out  N  per-slave strobe.
- wbs_cti_o  out  N*3  per-slave cycle type.
- wbs_bte_o  out  N*2  per-slave burst type.
- wbs_rdt_i  in  N*dw  per-slave read data.
- wbs_ack_i  in  N  per-slave ack.
- wbs_err_i  in  N  per-slave error.
- wbs_rty_i  in  N  per-slave retry.

Behaviour:

Decode:
- match[i] = ((wbm_adr_i & MATCH_MASK[i]) == MATCH_ADDR[i]).
- Decode is combinational.
- sel_idx = lowest i with match[i]=1; overlapping regions resolve to the lowest index.
- hit = |match.

Forward path (combinational):
- adr, dat, sel, we, cti and bte are replicated unmodified to every slave slot. The address is not offset-stripped; slaves mask it themselves.
- wbs_cyc_o[i] = wbm_cyc_i & hit & (i == sel_idx).
- wbs_stb_o[i] = wbm_stb_i & hit & (i == sel_idx).
- At most one bit of wbs_cyc_o is ever set.

Return path (combinational):
- wbm_rdt_o = wbs_rdt_i[sel_idx].
- wbm_ack_o = hit & wbs_ack_i[sel_idx].
- wbm_rty_o = hit & wbs_rty_i[sel_idx].
- Responses from non-selected slaves are ignored.

Error path:
- wbm_err_o = (hit & wbs_err_i[sel_idx]) | nomatch_err.
- nomatch_err is a register; on each rising edge:
  nomatch_err <= wbm_cyc_i & wbm_stb_i & ~hit & ~nomatch_err.
- An unmapped access therefore gets a one-cycle error pulse one cycle after strobe.
- If the master holds stb, the pulse repeats every other cycle.
- A strobe that is dropped before the edge produces no error.

Latency:
- Mapped accesses add zero cycles; ack timing equals the slave's.
- Bursts (cti=010) pass through unchanged. Each beat is re-decoded, so a burst crossing a region boundary switches slaves per beat.

Reset:
- While wb_rst_i=0: nomatch_err=0, all wbs_cyc_o/wbs_stb_o=0, and wbm_ack_o/wbm_err_o/wbm_rty_o=0.
- Data and address buses still pass through.
- Reset asserted mid-transfer drops the cycle immediately (asynchronous).
- After deassertion, normal decode resumes on the next edge with no pending error.

Simultaneity:
- If the address changes while a slave is acking, the response follows the new selection. Masters must hold the address stable until ack/err/rty, per Wishbone.

Test Plan:
- N=4, MATCH_ADDR={0x300,0x200,0x100,0x000}, MASK=0xFFFFFF00. Write 0xDEADBEEF to 0x104, then read 0x104 → only wbs_cyc_o[1] asserted; read returns 0xDEADBEEF; the write counters of slaves 0, 2 and 3 are unchanged.
- Same map, random single reads/writes across 0x000–0x3FC, sel=0xF and partial sels → every read matches a shadow model; per-slave write counts sum to the total writes.
- Access 0x400 (unmapped) → no wbs_cyc_o bit set; wbm_err_o=1 exactly one cycle after stb; wbm_ack_o stays 0.
- Overlapping map, slave0 mask 0 (matches all) and slave1 at 0x100 → access to 0x100 goes to slave 0 (lowest index wins).
- Incrementing burst of 8 beats (cti=010, bte=00) starting at 0x2F0 → beats 0x2F0–0x2FC go to slave 2 and beats 0x300–0x30C go to slave 3; all data correct.
- Assert wb_rst_i low mid-burst → wbs_cyc_o=0 and wbm_ack_o=0 immediately. After release, a read of 0x000 completes normally with no spurious err.

Source files
------------

// File: rtl/wb_addr_mux.sv
// Wishbone 1-to-N address decoder/multiplexer.
// Lowest matching slave wins; unmapped strobes get a one-cycle error.
module wb_addr_mux #(
   parameter int num_slaves = 2,
   parameter int aw = 32,
   parameter int dw = 32,
   parameter logic [num_slaves*aw-1:0] MATCH_ADDR = '0,
   parameter logic [num_slaves*aw-1:0] MATCH_MASK = '0
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic [aw-1:0]              wbm_adr_i,
   input  logic [dw-1:0]              wbm_dat_i,
   input  logic [dw/8-1:0]            wbm_sel_i,
   input  logic                       wbm_we_i,
   input  logic                       wbm_cyc_i,
   input  logic                       wbm_stb_i,
   input  logic [2:0]                 wbm_cti_i,
   input  logic [1:0]                 wbm_bte_i,
   output logic [dw-1:0]              wbm_rdt_o,
   output logic                       wbm_ack_o,
   output logic                       wbm_err_o,
   output logic                       wbm_rty_o,
   output logic [num_slaves*aw-1:0]   wbs_adr_o,
   output logic [num_slaves*dw-1:0]   wbs_dat_o,
   output logic [num_slaves*dw/8-1:0] wbs_sel_o,
   output logic [num_slaves-1:0]      wbs_we_o,
   output logic [num_slaves-1:0]      wbs_cyc_o,
   output logic [num_slaves-1:0]      wbs_stb_o,
   output logic [num_slaves*3-1:0]    wbs_cti_o,
   output logic [num_slaves*2-1:0]    wbs_bte_o,
   input  logic [num_slaves*dw-1:0]   wbs_rdt_i,
   input  logic [num_slaves-1:0]      wbs_ack_i,
   input  logic [num_slaves-1:0]      wbs_err_i,
   input  logic [num_slaves-1:0]      wbs_rty_i
);

   logic [num_slaves-1:0] match;
   logic [num_slaves-1:0] grant;
   logic                  hit;
   logic [dw-1:0]         rdt;
   logic                  ack_s;
   logic                  err_s;
   logic                  rty_s;
   logic                  nomatch_err_d;
   logic                  nomatch_err_q;

   // grant is the one-hot of the lowest-index match
   always_comb begin
      match = '0;
      grant = '0;
      for (int i = 0; i < num_slaves; i++) begin
         match[i] = (wbm_adr_i & MATCH_MASK[i*aw +: aw]) == MATCH_ADDR[i*aw +: aw];
         if (match[i] && grant == '0)
            grant[i] = 1'b1;
      end
   end

   assign hit = |match;

   assign wbs_adr_o = {num_slaves{wbm_adr_i}};
   assign wbs_dat_o = {num_slaves{wbm_dat_i}};
   assign wbs_sel_o = {num_slaves{wbm_sel_i}};
   assign wbs_we_o  = {num_slaves{wbm_we_i}};
   assign wbs_cti_o = {num_slaves{wbm_cti_i}};
   assign wbs_bte_o = {num_slaves{wbm_bte_i}};

   assign wbs_cyc_o = {num_slaves{wbm_cyc_i & wb_rst_i}} & grant;
   assign wbs_stb_o = {num_slaves{wbm_stb_i & wb_rst_i}} & grant;

   always_comb begin
      rdt   = '0;
      ack_s = 1'b0;
      err_s = 1'b0;
      rty_s = 1'b0;
      for (int i = 0; i < num_slaves; i++) begin
         if (grant[i]) begin
            rdt   = wbs_rdt_i[i*dw +: dw];
            ack_s = wbs_ack_i[i];
            err_s = wbs_err_i[i];
            rty_s = wbs_rty_i[i];
         end
      end
   end

   assign wbm_rdt_o = rdt;
   assign wbm_ack_o = wb_rst_i & ack_s;
   assign wbm_rty_o = wb_rst_i & rty_s;
   assign wbm_err_o = wb_rst_i & (err_s | nomatch_err_q);

   // self-clearing so a held strobe sees an error every other cycle
   always_comb begin
      nomatch_err_d = wbm_cyc_i & wbm_stb_i & ~hit & ~nomatch_err_q;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i)
         nomatch_err_q <= 1'b0;
      else
         nomatch_err_q <= nomatch_err_d;
   end

endmodule

// File: tb/tb_wb_addr_mux.sv
// Directed bench for wb_addr_mux: 4-slave map with memory slaves,
// plus a 2-slave overlapping map for priority.
module tb_wb_addr_mux;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   adr = '0;
   logic [31:0]   dat = '0;
   logic [3:0]    sel = '0;
   logic          we = 1'b0;
   logic          cyc = 1'b0;
   logic          stb = 1'b0;
   logic [2:0]    cti = '0;
   logic [1:0]    bte = '0;
   logic [31:0]   rdt;
   logic          ack;
   logic          err;
   logic          rty;
   logic [N*32-1:0] s_adr;
   logic [N*32-1:0] s_dat;
   logic [N*4-1:0]  s_sel;
   logic [N-1:0]    s_we;
   logic [N-1:0]    s_cyc;
   logic [N-1:0]    s_stb;
   logic [N*3-1:0]  s_cti;
   logic [N*2-1:0]  s_bte;
   logic [N*32-1:0] s_rdt;
   logic [N-1:0]    s_ack;

   logic [31:0] mem [N][64];
   int          wcnt [N];
   logic [31:0] shadow [256];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wb_addr_mux #(
      .num_slaves(N), .aw(32), .dw(32),
      .MATCH_ADDR({32'h300, 32'h200, 32'h100, 32'h000}),
      .MATCH_MASK({4{32'hFFFF_FF00}})
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst_n),
      .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel),
      .wbm_we_i(we), .wbm_cyc_i(cyc), .wbm_stb_i(stb),
      .wbm_cti_i(cti), .wbm_bte_i(bte),
      .wbm_rdt_o(rdt), .wbm_ack_o(ack), .wbm_err_o(err), .wbm_rty_o(rty),
      .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel),
      .wbs_we_o(s_we), .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb),
      .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
      .wbs_rdt_i(s_rdt), .wbs_ack_i(s_ack),
      .wbs_err_i('0), .wbs_rty_i('0)
   );

   logic [31:0] o_rdt;
   logic        o_ack, o_err, o_rty;
   logic [63:0] o_adr, o_dat;
   logic [7:0]  o_sel;
   logic [1:0]  o_we, o_cyc, o_stb;
   logic [5:0]  o_cti;
   logic [3:0]  o_bte;

   wb_addr_mux #(
      .num_slaves(2), .aw(32), .dw(32),
      .MATCH_ADDR({32'h100, 32'h000}),
      .MATCH_MASK({32'hFFFF_FF00, 32'h0})
   ) dut_ovl (
      .wb_clk_i(clk), .wb_rst_i(rst_n),
      .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel),
      .wbm_we_i(we), .wbm_cyc_i(cyc), .wbm_stb_i(stb),
      .wbm_cti_i(cti), .wbm_bte_i(bte),
      .wbm_rdt_o(o_rdt), .wbm_ack_o(o_ack), .wbm_err_o(o_err), .wbm_rty_o(o_rty),
      .wbs_adr_o(o_adr), .wbs_dat_o(o_dat), .wbs_sel_o(o_sel),
      .wbs_we_o(o_we), .wbs_cyc_o(o_cyc), .wbs_stb_o(o_stb),
      .wbs_cti_o(o_cti), .wbs_bte_o(o_bte),
      .wbs_rdt_i('0), .wbs_ack_i('0),
      .wbs_err_i('0), .wbs_rty_i('0)
   );

   // memory slaves: single-cycle registered ack, byte-masked writes
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ack <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            s_ack[i] <= s_cyc[i] & s_stb[i] & ~s_ack[i];
            if (s_cyc[i] && s_stb[i] && !s_ack[i] && s_we[i]) begin
               for (int b = 0; b < 4; b++)
                  if (s_sel[i*4+b])
                     mem[i][s_adr[i*32+2 +: 6]][b*8 +: 8] <= s_dat[i*32+b*8 +: 8];
               wcnt[i] <= wcnt[i] + 1;
            end
         end
      end
   end

   always_comb begin
      s_rdt = '0;
      for (int i = 0; i < N; i++)
         s_rdt[i*32 +: 32] = mem[i][s_adr[i*32+2 +: 6]];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r, output logic e,
                       output logic [N-1:0] cs);
      logic done;
      @(negedge clk);
      adr = a; we = w; dat = d; sel = s; cti = 3'b000;
      cyc = 1'b1; stb = 1'b1;
      done = 1'b0; r = '0; e = 1'b0; cs = '0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(posedge clk); #1;
         if (ack || err) begin
            done = 1'b1; r = rdt; e = err; cs = s_cyc;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (!done) chk("xfer_timeout", {63'd0, done}, 64'd1);
      if (w && !e && a < 32'h400) shadow[a[9:2]] = merge(shadow[a[9:2]], d, s);
   endtask

   // 8-beat incrementing burst; checks the per-beat slave selection
   task automatic burst(input logic [31:0] a0, input logic w, input logic [31:0] seed);
      logic        done;
      logic [31:0] a;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; bte = 2'b00;
      for (int bt = 0; bt < 8; bt++) begin
         a = a0 + 32'(bt * 4);
         adr = a; dat = seed ^ a;
         cti = (bt == 7) ? 3'b111 : 3'b010;
         done = 1'b0;
         for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk); #1;
            if (ack || err) begin
               done = 1'b1;
               chk($sformatf("burst_cyc_%0h", a), {60'd0, s_cyc}, 64'(4'b0001 << a[9:8]));
               if (w) shadow[a[9:2]] = seed ^ a;
               else chk($sformatf("burst_rd_%0h", a), {32'd0, rdt}, {32'd0, shadow[a[9:2]]});
            end
         end
         if (!done) chk("burst_timeout", {63'd0, done}, 64'd1);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
   endtask

   logic [31:0] r;
   logic        e;
   logic [N-1:0] cs;
   int          base [N];
   int          exp_w [N];
   int          tot_w;
   logic [31:0] ra;
   logic [3:0]  rs;
   logic        rw;
   logic [3:0]  sels [7] = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC};

   initial begin
      for (int i = 0; i < N; i++) wcnt[i] = 0;

      // reset gating with an active master request
      #12;
      adr = 32'h104; cyc = 1'b1; stb = 1'b1;
      #1;
      chk("rst_cyc", {60'd0, s_cyc}, 64'd0);
      chk("rst_stb", {60'd0, s_stb}, 64'd0);
      chk("rst_resp", {61'd0, ack, err, rty}, 64'd0);
      chk("rst_adr_pass", {32'd0, s_adr[63:32]}, 64'h104);
      @(posedge clk); #1;
      chk("rst_err_hold", {63'd0, err}, 64'd0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // fill every slave word so the shadow is fully known
      for (int w = 0; w < 256; w++) begin
         shadow[w] = '0;
         xfer(32'(w * 4), 1'b1, 32'hA5A5_0000 ^ 32'(w * 4), 4'hF, r, e, cs);
      end

      for (int i = 0; i < N; i++) base[i] = wcnt[i];
      xfer(32'h104, 1'b1, 32'hDEAD_BEEF, 4'hF, r, e, cs);
      chk("wr104_cyc", {60'd0, cs}, 64'h2);
      chk("wr104_err", {63'd0, e}, 64'd0);
      xfer(32'h104, 1'b0, '0, 4'hF, r, e, cs);
      chk("rd104_cyc", {60'd0, cs}, 64'h2);
      chk("rd104_data", {32'd0, r}, 64'hDEAD_BEEF);
      chk("wcnt0_same", 64'(wcnt[0] - base[0]), 64'd0);
      chk("wcnt1_inc", 64'(wcnt[1] - base[1]), 64'd1);
      chk("wcnt2_same", 64'(wcnt[2] - base[2]), 64'd0);
      chk("wcnt3_same", 64'(wcnt[3] - base[3]), 64'd0);

      // random single accesses against the shadow
      for (int i = 0; i < N; i++) begin base[i] = wcnt[i]; exp_w[i] = 0; end
      tot_w = 0;
      for (int t = 0; t < 60; t++) begin
         ra = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         rw = 1'($urandom_range(0, 1));
         rs = sels[$urandom_range(0, 6)];
         if (rw) begin
            xfer(ra, 1'b1, $urandom, rs, r, e, cs);
            exp_w[ra[9:8]]++;
            tot_w++;
         end else begin
            xfer(ra, 1'b0, '0, 4'hF, r, e, cs);
            chk($sformatf("rnd_rd_%0h", ra), {32'd0, r}, {32'd0, shadow[ra[9:2]]});
         end
      end
      for (int i = 0; i < N; i++)
         chk($sformatf("rnd_wcnt%0d", i), 64'(wcnt[i] - base[i]), 64'(exp_w[i]));
      chk("rnd_wsum", 64'((wcnt[0] - base[0]) + (wcnt[1] - base[1]) +
                          (wcnt[2] - base[2]) + (wcnt[3] - base[3])), 64'(tot_w));

      // unmapped access: error one cycle after strobe, repeats every other cycle
      @(negedge clk);
      adr = 32'h400; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      #1;
      chk("unm_cyc", {60'd0, s_cyc}, 64'd0);
      chk("unm_err_pre", {63'd0, err}, 64'd0);
      @(posedge clk); #1;
      chk("unm_err1", {62'd0, err, ack}, 64'b10);
      @(posedge clk); #1;
      chk("unm_err2", {62'd0, err, ack}, 64'b00);
      @(posedge clk); #1;
      chk("unm_err3", {62'd0, err, ack}, 64'b10);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      chk("unm_err_end", {63'd0, err}, 64'd0);

      // strobe dropped before the edge: no error
      @(negedge clk);
      adr = 32'h400; cyc = 1'b1; stb = 1'b1;
      #2;
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      chk("drop_stb_err", {63'd0, err}, 64'd0);

      // overlapping map: lowest index wins
      @(negedge clk);
      adr = 32'h100; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      #1;
      chk("ovl_cyc", {62'd0, o_cyc}, 64'b01);
      chk("ovl_stb", {62'd0, o_stb}, 64'b01);
      #1;
      cyc = 1'b0; stb = 1'b0;

      // burst crossing the 0x300 boundary
      for (int i = 0; i < N; i++) base[i] = wcnt[i];
      burst(32'h2F0, 1'b1, 32'h5A00_0000);
      chk("bst_wcnt2", 64'(wcnt[2] - base[2]), 64'd4);
      chk("bst_wcnt3", 64'(wcnt[3] - base[3]), 64'd4);
      burst(32'h2F0, 1'b0, 32'h0);

      // asynchronous reset mid-burst
      @(negedge clk);
      adr = 32'h000; we = 1'b0; sel = 4'hF; cti = 3'b010; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      chk("mid_ack_before", {63'd0, ack}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cyc", {60'd0, s_cyc}, 64'd0);
      chk("mid_rst_ack", {62'd0, ack, err}, 64'd0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; cti = 3'b000;
      @(negedge clk);
      rst_n = 1'b1;
      xfer(32'h000, 1'b0, '0, 4'hF, r, e, cs);
      chk("post_rst_data", {32'd0, r}, {32'd0, shadow[0]});
      chk("post_rst_err", {63'd0, e}, 64'd0);
      chk("post_rst_cyc", {60'd0, cs}, 64'd1);
      @(posedge clk); #1;
      chk("post_rst_idle_err", {63'd0, err}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
